// File: rtl/cond_unit.sv
// Condition-check and NZCV flag register for the single-cycle ARM core.
// Evaluates Cond against the registered flags and gates the decoder write enables.
module cond_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  logic [1:0] r_nz;
  logic [1:0] r_cv;
  logic       w_n;
  logic       w_z;
  logic       w_c;
  logic       w_v;
  logic       w_cond_ex;
  logic       w_nz_we;
  logic       w_cv_we;

  assign w_n = r_nz[1];
  assign w_z = r_nz[0];
  assign w_c = r_cv[1];
  assign w_v = r_cv[0];

  // Condition decode from registered flags only; 1111 is reserved and squashes.
  always_comb begin
    w_cond_ex = 1'b0;
    case (Cond)
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = ~w_z;
      4'b0010: w_cond_ex = w_c;
      4'b0011: w_cond_ex = ~w_c;
      4'b0100: w_cond_ex = w_n;
      4'b0101: w_cond_ex = ~w_n;
      4'b0110: w_cond_ex = w_v;
      4'b0111: w_cond_ex = ~w_v;
      4'b1000: w_cond_ex = w_c & ~w_z;
      4'b1001: w_cond_ex = ~w_c | w_z;
      4'b1010: w_cond_ex = (w_n == w_v);
      4'b1011: w_cond_ex = (w_n != w_v);
      4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
      4'b1101: w_cond_ex = w_z | (w_n != w_v);
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  assign w_nz_we = FlagW[1] & w_cond_ex;
  assign w_cv_we = FlagW[0] & w_cond_ex;

  // N,Z pair: written only when the instruction passes and requests it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_nz <= 2'b00;
    end else if (w_nz_we) begin
      r_nz <= ALUFlags[3:2];
    end else begin
      r_nz <= r_nz;
    end
  end

  // C,V pair: independent write enable so logical ops can leave C,V intact.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cv <= 2'b00;
    end else if (w_cv_we) begin
      r_cv <= ALUFlags[1:0];
    end else begin
      r_cv <= r_cv;
    end
  end

  assign CondEx   = w_cond_ex;
  assign PCSrc    = PCS & w_cond_ex;
  assign RegWrite = RegW & w_cond_ex & ~NoWrite;
  assign MemWrite = MemW & w_cond_ex;
  assign Flags    = {r_nz, r_cv};

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit.
module tb_cond_unit;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic [3:0] Flags;

  int checks;
  int failures;

  cond_unit dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .NoWrite  (NoWrite),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
    .Flags    (Flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference condition table written directly from the ARM condition semantics.
  function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n ~^ v;
      4'd11: return n ^ v;
      4'd12: return !z && (n ~^ v);
      4'd13: return z || (n ^ v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b0; Cond = 4'b1110; RegW = 1'b1; FlagW = 2'b00;
    #1;
    checks++;
    if (Flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", Flags); end
    checks++;
    if (CondEx !== 1'b1) begin failures++; $display("FAIL reset_al_condex got=%b exp=1", CondEx); end
    checks++;
    if (RegWrite !== 1'b1) begin failures++; $display("FAIL reset_al_regwrite got=%b exp=1", RegWrite); end
    Cond = 4'b0000; #1;
    checks++;
    if (CondEx !== 1'b0) begin failures++; $display("FAIL reset_eq_condex got=%b exp=0", CondEx); end
    checks++;
    if (RegWrite !== 1'b0) begin failures++; $display("FAIL reset_eq_regwrite got=%b exp=0", RegWrite); end
    Cond = 4'b0001; #1;
    checks++;
    if (CondEx !== 1'b1) begin failures++; $display("FAIL reset_ne_condex got=%b exp=1", CondEx); end
    @(negedge clk);
    reset = 1'b1; RegW = 1'b0;
  endtask

  task automatic test_subs_eq();
    @(negedge clk);
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0110;
    @(posedge clk); #1;
    checks++;
    if (Flags !== 4'b0110) begin failures++; $display("FAIL subs_flags got=%b exp=0110", Flags); end
    FlagW = 2'b00; Cond = 4'b0000; RegW = 1'b1; MemW = 1'b1; ALUFlags = 4'b1111;
    #1;
    checks++;
    if (CondEx !== 1'b1) begin failures++; $display("FAIL eq_condex got=%b exp=1", CondEx); end
    checks++;
    if (RegWrite !== 1'b1) begin failures++; $display("FAIL eq_regwrite got=%b exp=1", RegWrite); end
    checks++;
    if (MemWrite !== 1'b1) begin failures++; $display("FAIL eq_memwrite got=%b exp=1", MemWrite); end
    @(posedge clk); #1;
    checks++;
    if (Flags !== 4'b0110) begin failures++; $display("FAIL flagw00_hold got=%b exp=0110", Flags); end
  endtask

  task automatic test_squash();
    @(negedge clk);
    Cond = 4'b0001; FlagW = 2'b11; ALUFlags = 4'b1000; RegW = 1'b1; PCS = 1'b1; MemW = 1'b1;
    #1;
    checks++;
    if (CondEx !== 1'b0) begin failures++; $display("FAIL squash_condex got=%b exp=0", CondEx); end
    checks++;
    if ({PCSrc, RegWrite, MemWrite} !== 3'b000) begin
      failures++; $display("FAIL squash_gates got=%b exp=000", {PCSrc, RegWrite, MemWrite});
    end
    @(posedge clk); #1;
    checks++;
    if (Flags !== 4'b0110) begin failures++; $display("FAIL squash_flags got=%b exp=0110", Flags); end
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; FlagW = 2'b00;
  endtask

  task automatic test_partial_signed();
    @(negedge clk);
    Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b1001;
    @(posedge clk); #1;
    checks++;
    if (Flags !== 4'b1010) begin failures++; $display("FAIL partial_flags got=%b exp=1010", Flags); end
    FlagW = 2'b00;
    Cond = 4'b1010; #1;
    checks++;
    if (CondEx !== 1'b0) begin failures++; $display("FAIL ge_condex got=%b exp=0", CondEx); end
    Cond = 4'b1011; #1;
    checks++;
    if (CondEx !== 1'b1) begin failures++; $display("FAIL lt_condex got=%b exp=1", CondEx); end
    Cond = 4'b1101; #1;
    checks++;
    if (CondEx !== 1'b1) begin failures++; $display("FAIL le_condex got=%b exp=1", CondEx); end
    Cond = 4'b1100; #1;
    checks++;
    if (CondEx !== 1'b0) begin failures++; $display("FAIL gt_condex got=%b exp=0", CondEx); end
  endtask

  task automatic test_async_reset_nowrite();
    @(negedge clk);
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111;
    @(posedge clk); #1;
    checks++;
    if (Flags !== 4'b1111) begin failures++; $display("FAIL load1111_flags got=%b exp=1111", Flags); end
    FlagW = 2'b00; Cond = 4'b0000;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (Flags !== 4'b0000) begin failures++; $display("FAIL async_reset_flags got=%b exp=0000", Flags); end
    checks++;
    if (CondEx !== 1'b0) begin failures++; $display("FAIL async_reset_eq got=%b exp=0", CondEx); end
    @(negedge clk);
    reset = 1'b1;
    Cond = 4'b1110; RegW = 1'b1; NoWrite = 1'b1;
    #1;
    checks++;
    if (CondEx !== 1'b1) begin failures++; $display("FAIL nowrite_condex got=%b exp=1", CondEx); end
    checks++;
    if (RegWrite !== 1'b0) begin failures++; $display("FAIL nowrite_regwrite got=%b exp=0", RegWrite); end
    RegW = 1'b0; NoWrite = 1'b0;
  endtask

  task automatic test_no_bypass_and_cond_write();
    // Flags are 0000 here; EQ must not see the pending ALU Z.
    @(negedge clk);
    Cond = 4'b0000; FlagW = 2'b00; ALUFlags = 4'b0100;
    #1;
    checks++;
    if (CondEx !== 1'b0) begin failures++; $display("FAIL no_bypass got=%b exp=0", CondEx); end
    @(negedge clk);
    Cond = 4'b0001; FlagW = 2'b11; ALUFlags = 4'b0100;
    #1;
    checks++;
    if (CondEx !== 1'b1) begin failures++; $display("FAIL subsne_old_flags got=%b exp=1", CondEx); end
    @(posedge clk); #1;
    checks++;
    if (Flags !== 4'b0100) begin failures++; $display("FAIL subsne_flags got=%b exp=0100", Flags); end
    FlagW = 2'b00;
    checks++;
    if (CondEx !== 1'b0) begin failures++; $display("FAIL ne_after_z got=%b exp=0", CondEx); end
  endtask

  task automatic test_sweep();
    for (int f = 0; f < 16; f++) begin
      @(negedge clk);
      Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'(f);
      @(posedge clk); #1;
      FlagW = 2'b00;
      checks++;
      if (Flags !== 4'(f)) begin failures++; $display("FAIL sweep_load got=%b exp=%b", Flags, 4'(f)); end
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        Cond = 4'(c);
        #1;
        checks++;
        if (CondEx !== ref_cond(4'(f), 4'(c))) begin
          failures++;
          $display("FAIL sweep_cond flags=%b cond=%b got=%b exp=%b", 4'(f), 4'(c), CondEx, ref_cond(4'(f), 4'(c)));
        end
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; Cond = 4'b0000; ALUFlags = 4'b0000; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
    test_reset();
    test_subs_eq();
    test_squash();
    test_partial_signed();
    test_async_reset_nowrite();
    test_no_bypass_and_cond_write();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
# cond_unit

Condition-check and flag-register unit for the single-cycle ARM processor. It is the consuming end of the ALU's `ALUFlags` output: it holds the architectural NZCV flags and evaluates each instruction's 4-bit condition field against them. It gates the decoder's write enables (`PCS`, `RegW`, `MemW`, `FlagW`) so a failed condition has no architectural effect. It sits between the main decoder/ALU and the register file, data memory and PC logic.

## Interface
No parameters. The widths are fixed by the ISA.

- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset; clears the flag register
- `Cond`  in  4  instruction condition field, `Instr[31:28]`
- `ALUFlags`  in  4  ALU result flags `{N,Z,C,V}` for the current instruction
- `FlagW`  in  2  decoder flag-write request; bit 1 = N,Z; bit 0 = C,V
- `PCS`  in  1  decoder: instruction writes the PC
- `RegW`  in  1  decoder: instruction writes the register file
- `MemW`  in  1  decoder: instruction writes data memory
- `NoWrite`  in  1  decoder: compare-class op (CMP); suppresses the register write
- `PCSrc`  out  1  gated PC write
- `RegWrite`  out  1  gated register write
- `MemWrite`  out  1  gated memory write
- `CondEx`  out  1  condition passed for the current instruction
- `Flags`  out  4  current registered `{N,Z,C,V}`, for debug/visibility

## Operation
**Flag register.** Four flops: N, Z, C, V.
- N,Z load `ALUFlags[3:2]` on the rising edge when `FlagW[1] & CondEx` is true.
- C,V load `ALUFlags[1:0]` on the rising edge when `FlagW[0] & CondEx` is true.
- A flag pair that is not written holds its value.

**CondEx.** Combinational from `Cond` and the registered flags, never from `ALUFlags`. The current instruction sees only the flags set by earlier instructions.
- 0000 EQ: Z
- 0001 NE: !Z
- 0010 CS: C
- 0011 CC: !C
- 0100 MI: N
- 0101 PL: !N
- 0110 VS: V
- 0111 VC: !V
- 1000 HI: C & !Z
- 1001 LS: !C | Z
- 1010 GE: N == V
- 1011 LT: N != V
- 1100 GT: !Z & (N == V)
- 1101 LE: Z | (N != V)
- 1110 AL: 1
- 1111: reserved; CondEx = 0, so the instruction is squashed.

**Gated outputs** (combinational):
- `PCSrc = PCS & CondEx`
- `RegWrite = RegW & CondEx & !NoWrite`
- `MemWrite = MemW & CondEx`

**Flags** mirrors the flag register directly.

## Timing
- Reset: while `reset` = 0, Flags = 0000 immediately, independent of `clk`.
- Outputs under reset follow from Flags = 0000. With `Cond` = 0001 (NE), CondEx = 1. With `Cond` = 0000 (EQ), CondEx = 0. Gated outputs follow CondEx.
- Reset asserted mid-cycle: flags clear at once and CondEx re-evaluates combinationally in the same cycle. Release is synchronous to the next rising edge; the first flag update can occur on the first edge after release.
- Latency: flags written by instruction k are visible to instruction k+1 (one edge). There is no bypass from `ALUFlags` to CondEx.
- Same instruction evaluates a condition and writes flags (e.g. SUBSEQ): the condition uses the old flags, and the update is conditional on that result.
- Gated outputs and CondEx have zero-cycle combinational latency from `Cond`, `PCS`, `RegW`, `MemW` and `NoWrite`.
- `FlagW` = 00: no flag change, regardless of `ALUFlags`.
- No X propagation: every `Cond` encoding maps to a defined CondEx.

## Test plan
- **Reset and AL.** Drive reset = 0 and Cond = 1110, RegW = 1 -> Flags = 0000, CondEx = 1, RegWrite = 1. Then Cond = 0000 -> CondEx = 0, RegWrite = 0.
- **SUBS equal then EQ.** After reset release, Cond = 1110, FlagW = 11, ALUFlags = 0110 (5−5), one edge -> Flags = 0110. Then Cond = 0000, RegW = 1, MemW = 1 -> CondEx = 1, RegWrite = 1, MemWrite = 1.
- **Failed condition squashes everything.** From Flags = 0110: Cond = 0001 (NE), FlagW = 11, ALUFlags = 1000, RegW = PCS = MemW = 1 -> CondEx = 0, all gated outputs 0. After the edge, Flags is still 0110.
- **Partial write and signed conditions.** From Flags = 0110: Cond = 1110, FlagW = 10, ALUFlags = 1001, one edge -> Flags = 1010 (C,V held). Then Cond = 1010 (GE) -> CondEx = 0; Cond = 1011 (LT) -> CondEx = 1; Cond = 1101 (LE) -> CondEx = 1.
- **Async reset mid-cycle and NoWrite.** With Flags = 1111, pull reset low between edges -> Flags = 0000 before the next edge, Cond = 0000 gives CondEx = 0. After release: Cond = 1110, RegW = 1, NoWrite = 1 -> RegWrite = 0 while CondEx = 1.
- **Exhaustive sweep.** Load each of the 16 flag values via FlagW = 11, Cond = 1110. For each, apply all 16 Cond codes -> CondEx matches the reference condition table, with Cond = 1111 always 0.
